// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage registers:
//   - FSM state encoding of the two-slot stage register (EMPTY/ONE/TWO)
//   - default payload widths
//   - default-width payload struct {we, wsel, data}
//   - helper that computes the write enable actually stored in a slot
// -----------------------------------------------------------------------------
package pipe_pkg;

   // Default widths used when a stage is instantiated without overrides
   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_SEL_W  = 5;
   localparam int PIPE_CNT_W  = 16;

   // Slot occupancy of the stage register
   typedef enum logic [1:0] {
      PIPE_EMPTY = 2'd0,
      PIPE_ONE   = 2'd1,
      PIPE_TWO   = 2'd2
   } pipe_state_e;

   // Legacy-compatible constants for the same encoding
   localparam logic [1:0] ST_EMPTY = PIPE_EMPTY;
   localparam logic [1:0] ST_ONE   = PIPE_ONE;
   localparam logic [1:0] ST_TWO   = PIPE_TWO;

   // Payload carried by one slot at the default widths
   typedef struct packed {
      logic                   we;
      logic [PIPE_SEL_W-1:0]  wsel;
      logic [PIPE_DATA_W-1:0] data;
   } pipe_payload_t;

   // A write to register 0 is architecturally a no-op; when suppression is on
   // the slot keeps the payload but drops the write enable.
   function automatic logic pipe_stored_we(input logic we,
                                           input logic wsel_is_zero,
                                           input logic suppress);
      pipe_stored_we = we & ~(suppress & wsel_is_zero);
   endfunction

endpackage

// File: rtl/wb_stage_reg.sv
// -----------------------------------------------------------------------------
// wb_stage_reg
// EX->WB pipeline stage register with valid/ready handshake and a two-entry
// skid buffer so that in_ready comes straight from a flop.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop every held entry and any entry offered this cycle
//   in_valid/ready  upstream handshake (in_ready is registered)
//   in_we/wsel/data upstream payload
//   out_valid/ready downstream handshake towards the register-file write port
//   out_we/wsel/data registered payload; out_we is 0 whenever out_valid is 0
//   stall_cnt       saturating count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module wb_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W            = PIPE_DATA_W,
   parameter int SEL_W             = PIPE_SEL_W,
   parameter bit ZERO_REG_SUPPRESS = 1'b1,
   parameter int CNT_W             = PIPE_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_we,
   input  logic [SEL_W-1:0]  in_wsel,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_we,
   output logic [SEL_W-1:0]  out_wsel,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef struct packed {
      logic              we;
      logic [SEL_W-1:0]  wsel;
      logic [DATA_W-1:0] data;
   } payload_t;

   logic [1:0] r_state;
   payload_t   r_main;
   payload_t   r_skid;
   logic       r_in_ready;
   logic       r_out_valid;
   logic [CNT_W-1:0] r_stall_cnt;

   logic       w_acc;
   logic       w_pop;
   payload_t   w_in_pl;
   logic [1:0] w_state_nxt;
   logic       w_main_from_in;
   logic       w_main_from_skid;
   logic       w_skid_from_in;

   assign w_acc = in_valid & r_in_ready;
   assign w_pop = r_out_valid & out_ready;

   // Incoming payload as it will be stored (register-0 writes lose their we)
   always_comb begin
      w_in_pl.we   = pipe_stored_we(in_we, (in_wsel == {SEL_W{1'b0}}), ZERO_REG_SUPPRESS);
      w_in_pl.wsel = in_wsel;
      w_in_pl.data = in_data;
   end

   // Next-state and slot-load decisions; flush only overrides the next state,
   // since payload contents of empty slots are never observed.
   always_comb begin
      w_state_nxt      = r_state;
      w_main_from_in   = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_acc) begin
               w_main_from_in = 1'b1;
               w_state_nxt    = ST_ONE;
            end else begin
               w_state_nxt    = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (w_acc && w_pop) begin
               w_main_from_in = 1'b1;
               w_state_nxt    = ST_ONE;
            end else if (w_acc) begin
               w_skid_from_in = 1'b1;
               w_state_nxt    = ST_TWO;
            end else if (w_pop) begin
               w_state_nxt    = ST_EMPTY;
            end else begin
               w_state_nxt    = ST_ONE;
            end
         end
         ST_TWO: begin
            // in_ready is low here, so no accept can coincide with the pop
            if (w_pop) begin
               w_main_from_skid = 1'b1;
               w_state_nxt      = ST_ONE;
            end else begin
               w_state_nxt      = ST_TWO;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         w_state_nxt = w_state_nxt;
      end
   end

   // State, slot payloads and the registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_EMPTY;
         r_main      <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != ST_TWO);
         r_out_valid <= (w_state_nxt != ST_EMPTY);
         if (w_main_from_in) begin
            r_main <= w_in_pl;
         end else if (w_main_from_skid) begin
            r_main <= r_skid;
         end else begin
            r_main <= r_main;
         end
         if (w_skid_from_in) begin
            r_skid <= w_in_pl;
         end else begin
            r_skid <= r_skid;
         end
      end
   end

   // Saturating count of cycles in which WB holds off a valid entry
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= {CNT_W{1'b0}};
      end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1'b1);
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_we    = r_main.we & r_out_valid;
   assign out_wsel  = r_main.wsel;
   assign out_data  = r_main.data;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_wb_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_wb_stage_reg
// Drives three instances of wb_stage_reg from the same inputs:
//   dut     default parameters
//   dut_nz  ZERO_REG_SUPPRESS = 0 (only out_we differs)
//   dut_sat CNT_W = 3 (only stall_cnt differs)
// A reference model keeps the held entries as a FIFO queue of at most two.
// -----------------------------------------------------------------------------
module tb_wb_stage_reg;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_we;
   logic [4:0]  in_wsel;
   logic [31:0] in_data;
   logic        out_ready;

   logic        in_ready,  in_ready_nz,  in_ready_sat;
   logic        out_valid, out_valid_nz, out_valid_sat;
   logic        out_we,    out_we_nz,    out_we_sat;
   logic [4:0]  out_wsel,  out_wsel_nz,  out_wsel_sat;
   logic [31:0] out_data,  out_data_nz,  out_data_sat;
   logic [15:0] stall_cnt, stall_cnt_nz;
   logic [2:0]  stall_cnt_sat;

   wb_stage_reg dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_we(in_we), .in_wsel(in_wsel), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_we(out_we), .out_wsel(out_wsel), .out_data(out_data),
      .stall_cnt(stall_cnt)
   );

   wb_stage_reg #(.ZERO_REG_SUPPRESS(1'b0)) dut_nz (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_nz),
      .in_we(in_we), .in_wsel(in_wsel), .in_data(in_data),
      .out_valid(out_valid_nz), .out_ready(out_ready),
      .out_we(out_we_nz), .out_wsel(out_wsel_nz), .out_data(out_data_nz),
      .stall_cnt(stall_cnt_nz)
   );

   wb_stage_reg #(.CNT_W(3)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_sat),
      .in_we(in_we), .in_wsel(in_wsel), .in_data(in_data),
      .out_valid(out_valid_sat), .out_ready(out_ready),
      .out_we(out_we_sat), .out_wsel(out_wsel_sat), .out_data(out_data_sat),
      .stall_cnt(stall_cnt_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit        we;
      bit [4:0]  wsel;
      bit [31:0] data;
   } ent_t;

   ent_t    q[$];
   longint  m_stall;
   int      n_tests;
   int      n_fail;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Compare every output of the three instances with the model
   task automatic check_outputs();
      longint sat16;
      longint sat3;
      sat16 = (m_stall > 65535) ? 65535 : m_stall;
      sat3  = (m_stall > 7) ? 7 : m_stall;
      check("out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
      check("in_ready",  {63'd0, in_ready},  {63'd0, (q.size() < 2)});
      check("stall_cnt", {48'd0, stall_cnt}, sat16);
      check("stall_sat", {61'd0, stall_cnt_sat}, sat3);
      if (q.size() > 0) begin
         check("out_data", {32'd0, out_data}, {32'd0, q[0].data});
         check("out_wsel", {59'd0, out_wsel}, {59'd0, q[0].wsel});
         check("out_we",   {63'd0, out_we},
               {63'd0, (q[0].we && (q[0].wsel != 5'd0))});
         check("out_we_nz", {63'd0, out_we_nz}, {63'd0, q[0].we});
      end else begin
         check("out_we_idle",    {63'd0, out_we},    64'd0);
         check("out_we_nz_idle", {63'd0, out_we_nz}, 64'd0);
      end
   endtask

   // One clock: update the model with the inputs seen at the edge, then check
   task automatic step();
      bit   pop;
      bit   acc;
      ent_t e;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_stall = 0;
      end else begin
         pop = (q.size() > 0) && out_ready;
         acc = in_valid && (q.size() < 2);
         if ((q.size() > 0) && !out_ready) m_stall++;
         if (pop) void'(q.pop_front());
         if (flush) begin
            q.delete();
         end else if (acc) begin
            e.we = in_we; e.wsel = in_wsel; e.data = in_data;
            q.push_back(e);
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic drive(input bit v, input bit we, input bit [4:0] sel, input bit [31:0] d);
      in_valid = v; in_we = we; in_wsel = sel; in_data = d;
   endtask

   initial begin
      n_tests = 0; n_fail = 0; m_stall = 0;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, 1'b1, 5'd7, 32'h1234_5678);

      // Reset held for two cycles with in_valid high
      step(); step();
      rst = 1'b0; drive(1'b0, 1'b0, 5'd0, 32'd0);
      check("rst_wsel", {59'd0, out_wsel}, 64'd0);
      check("rst_data", {32'd0, out_data}, 64'd0);
      step();

      // Streaming: 1..8 back to back with out_ready high
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 1'b1, 5'd3, 32'(i));
         step();
      end
      drive(1'b0, 1'b0, 5'd0, 32'd0);
      step();

      // Backpressure: A, B stored, C held by the source while in_ready is low
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 5'd9, 32'hA);
      step();
      drive(1'b1, 1'b1, 5'd10, 32'hB);
      step();
      drive(1'b1, 1'b1, 5'd11, 32'hC);
      for (int i = 0; i < 4; i++) step();
      out_ready = 1'b1;
      step();
      step();
      drive(1'b0, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 3; i++) step();

      // Zero-register write
      drive(1'b1, 1'b1, 5'd0, 32'hDEAD);
      out_ready = 1'b0;
      step();
      drive(1'b0, 1'b0, 5'd0, 32'd0);
      check("zr_we_sup", {63'd0, out_we}, 64'd0);
      check("zr_we_nz",  {63'd0, out_we_nz}, 64'd1);
      check("zr_data",   {32'd0, out_data}, 64'h0000_DEAD);

      // Saturation: hold the entry for 10 more stalled cycles
      for (int i = 0; i < 10; i++) step();
      check("sat_at_7", {61'd0, stall_cnt_sat}, 64'd7);

      // Fill to TWO, then flush with in_valid and out_ready high
      drive(1'b1, 1'b1, 5'd4, 32'hBEEF);
      step();
      drive(1'b1, 1'b1, 5'd5, 32'hCAFE);
      flush = 1'b1; out_ready = 1'b1;
      step();
      flush = 1'b0; drive(1'b0, 1'b0, 5'd0, 32'd0);
      check("flush_valid", {63'd0, out_valid}, 64'd0);
      check("flush_ready", {63'd0, in_ready}, 64'd1);
      for (int i = 0; i < 3; i++) step();

      // Randomized traffic including occasional flush and reset
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         rst       = ($urandom_range(0, 150) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage_reg.md
# wb_stage_reg

Parametrised EX→WB pipeline stage register, the successor to the fixed 32-bit stage-3 register. Carries write-enable, write-select and result payload with a valid/ready handshake, a 2-entry skid buffer so the upstream ready is registered, a synchronous flush, and a saturating stall counter. Sits between the ALU stage and the register-file write port.

## Interface
- DATA_W, 32, result payload width (≥1)
- SEL_W, 5, write-select width (≥1)
- ZERO_REG_SUPPRESS, 1, when 1 a write with select==0 is stored with we=0
- CNT_W, 16, stall counter width (≥1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- in_we  in  1  write enable
- in_wsel  in  SEL_W  write select
- in_data  in  DATA_W  ALU result
- out_valid  out  1  entry presented to WB
- out_ready  in  1  WB accepts
- out_we  out  1  write enable, forced 0 when out_valid=0
- out_wsel  out  SEL_W  write select
- out_data  out  DATA_W  result
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Two slots: main (drives outputs) and skid. States: EMPTY (no slot valid), ONE (main valid), TWO (main+skid valid).
- in_ready = registered (state != TWO). acc = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY: acc → load main, go ONE.
- ONE: acc&pop → main←in, stay ONE; acc&!pop → skid←in, go TWO; !acc&pop → EMPTY; else hold.
- TWO: pop → main←skid, go ONE (no acc possible); else hold.
- Order within slots is FIFO; no entry is ever duplicated or dropped except by flush/rst.
- Stored we = in_we & !(ZERO_REG_SUPPRESS & in_wsel==0).
- flush: next state EMPTY, both slot valids cleared; a pop in the flush cycle still completes; an acc in the flush cycle is discarded. Payload registers need not clear. stall_cnt unaffected.
- stall_cnt increments when out_valid & !out_ready, holds at all-ones.
- Out-of-state payload contents are don't-care, but out_we must be 0 whenever out_valid=0.

## Timing
- Reset values: state EMPTY, out_valid 0, out_we 0, out_wsel 0, out_data 0, in_ready 1, stall_cnt 0. rst overrides flush and all handshakes.
- Latency: 1 cycle from acc in EMPTY to out_valid.
- Throughput: 1 entry/cycle sustained with out_ready held 1.
- in_ready deasserts the cycle after entering TWO, reasserts the cycle after leaving it; no combinational path from out_ready to in_ready.
- All outputs are flop outputs (out_we is flop AND out_valid flop, permitted).
- Reset mid-stream: all entries lost, next cycle identical to post-reset.

## Structure
- Shared package pipe_pkg: state enum (EMPTY/ONE/TWO), default DATA_W/SEL_W localparams, payload struct {we, wsel, data} parametrised via package constants.
- No sub-module; one always_ff for state/slots, one for stall_cnt.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 → out_valid=0, out_we=0, in_ready=1, stall_cnt=0 cycle after release.
- Streaming: out_ready=1, push data 1..8 wsel 3 we 1 back-to-back → outputs 1..8 in order, each 1 cycle after input, in_ready stays 1.
- Backpressure: out_ready=0, push A,B,C → A at output, B in skid, in_ready=0 after B, C held by source; release out_ready → A,B,C in order, stall_cnt equals stalled cycles.
- Zero-reg: push we=1 wsel=0 data 0xDEAD → out_valid=1, out_we=0, out_data=0xDEAD; with ZERO_REG_SUPPRESS=0 out_we=1.
- Flush: state TWO, assert flush with in_valid=1 and out_ready=1 → main popped that cycle, next cycle out_valid=0, in_ready=1, skid and incoming entries never appear.
- Saturation: CNT_W=3, hold out_valid with out_ready=0 for 10 cycles → stall_cnt stops at 7.
